// File: rtl/gpo_seq_pkg.sv
// rtl/gpo_seq_pkg.sv - shared state, register map and bit positions for the gpo sequencer slot
package gpo_seq_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [4:0] ADDR_CTRL    = 5'd0;
  localparam logic [4:0] ADDR_STATUS  = 5'd1;
  localparam logic [4:0] ADDR_LEN     = 5'd2;
  localparam logic [4:0] ADDR_PRESC   = 5'd3;
  localparam logic [4:0] ADDR_IDLEVAL = 5'd4;
  localparam logic [4:0] ENTRY_BASE   = 5'd16;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_LOOP  = 2;
`ifdef GPO_SEQ_IRQ_EN
  localparam int CTRL_IRQ_EN = 3;
`endif

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_IDX_LSB = 8;

endpackage

// File: rtl/gpo_seq_tick.sv
// rtl/gpo_seq_tick.sv - prescaler producing one tick every presc+1 clocks while not cleared
module gpo_seq_tick #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q;

  // >= rather than == so a live PRESC decrease below the count wraps at once
  assign tick = !clr && (cnt_q >= presc);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr || (cnt_q >= presc)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/gpo_seq_core.sv
// rtl/gpo_seq_core.sv - MMIO slot sequencing dout through a pattern/dwell table
// Optional irq output and CTRL irq_en bit enabled by GPO_SEQ_IRQ_EN.
module gpo_seq_core
  import gpo_seq_pkg::*;
#(
  parameter int W       = 8,
  parameter int DEPTH   = 16,
  parameter int PRESC_W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
`ifdef GPO_SEQ_IRQ_EN
  output logic         irq,
`endif
  output logic [W-1:0] dout
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_inc;
  logic [15:0]        dwell_cnt_q, dwell_cnt_d, dwell_cur, dwell_lim;
  logic [W-1:0]       dout_q, dout_d;
  logic               done_q, done_d;

  logic               loop_q;
  logic [IDX_W-1:0]   len_q;
  logic [PRESC_W-1:0] presc_q;
  logic [W-1:0]       idleval_q, idleval_d;
  logic [W-1:0]       pat_q   [DEPTH];
  logic [15:0]        dwell_q [DEPTH];

  logic               wr_en, ctrl_wr, start_cmd, stop_cmd, tick, tick_clr;
  logic [4:0]         ent_off;
  logic               ent_hit;
  logic [IDX_W-1:0]   ent_idx;
  logic               unused_wr;

  assign wr_en     = cs && write;
  assign ctrl_wr   = wr_en && (addr == ADDR_CTRL);
  // a combined start+stop write resolves to stop
  assign start_cmd = ctrl_wr && wr_data[CTRL_START] && !wr_data[CTRL_STOP];
  assign stop_cmd  = ctrl_wr && wr_data[CTRL_STOP];
  assign ent_off   = addr - ENTRY_BASE;
  assign ent_hit   = (addr >= ENTRY_BASE) && (ent_off < 5'(DEPTH));
  assign ent_idx   = ent_off[IDX_W-1:0];
  assign unused_wr = ^wr_data;

  assign idleval_d = (wr_en && addr == ADDR_IDLEVAL) ? wr_data[W-1:0] : idleval_q;
  assign idx_inc   = idx_q + IDX_W'(1);
  assign dwell_cur = dwell_q[idx_q];
  assign dwell_lim = (dwell_cur == 16'd0) ? 16'd0 : dwell_cur - 16'd1;
  assign tick_clr  = (state_q != RUN) || start_cmd || stop_cmd;
  assign dout      = dout_q;

  gpo_seq_tick #(.PRESC_W(PRESC_W)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tick_clr),
    .presc   (presc_q),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loop_q    <= 1'b0;
      len_q     <= '0;
      presc_q   <= '0;
      idleval_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pat_q[i]   <= '0;
        dwell_q[i] <= '0;
      end
    end else begin
      idleval_q <= idleval_d;
      if (ctrl_wr) loop_q <= wr_data[CTRL_LOOP];
      if (wr_en && addr == ADDR_LEN) len_q <= wr_data[IDX_W-1:0];
      if (wr_en && addr == ADDR_PRESC) presc_q <= wr_data[PRESC_W-1:0];
      if (wr_en && ent_hit) begin
        pat_q[ent_idx]   <= wr_data[W-1:0];
        dwell_q[ent_idx] <= wr_data[31:16];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      dwell_cnt_q <= '0;
      dout_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dwell_cnt_q <= dwell_cnt_d;
      dout_q      <= dout_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dwell_cnt_d = dwell_cnt_q;
    dout_d      = dout_q;
    done_d      = done_q;
    if (wr_en && addr == ADDR_STATUS) done_d = 1'b0;
    case (state_q)
      IDLE: begin
        dout_d = idleval_d;
        if (start_cmd) begin
          state_d     = RUN;
          idx_d       = '0;
          dwell_cnt_d = '0;
          dout_d      = pat_q[0];
          done_d      = 1'b0;
        end
      end
      RUN: begin
        if (stop_cmd) begin
          state_d = IDLE;
          dout_d  = idleval_d;
        end else if (start_cmd) begin
          idx_d       = '0;
          dwell_cnt_d = '0;
          dout_d      = pat_q[0];
          done_d      = 1'b0;
        end else if (tick) begin
          if (dwell_cnt_q >= dwell_lim) begin
            dwell_cnt_d = '0;
            // idx above a freshly shrunk LEN ends or loops like idx == LEN
            if (idx_q < len_q) begin
              idx_d  = idx_inc;
              dout_d = pat_q[idx_inc];
            end else if (loop_q) begin
              idx_d  = '0;
              dout_d = pat_q[0];
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
              dout_d  = idleval_d;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef GPO_SEQ_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q;

  assign irq_en_d = ctrl_wr ? wr_data[CTRL_IRQ_EN] : irq_en_q;
  assign irq      = irq_q;

  // built from next-state values so irq tracks done edge for edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= done_d && irq_en_d;
    end
  end
`endif

  always_comb begin
    rd_data = '0;
    if (cs && read) begin
      if (ent_hit) begin
        rd_data = {dwell_q[ent_idx], 16'(pat_q[ent_idx])};
      end else begin
        case (addr)
          ADDR_CTRL: begin
            rd_data[CTRL_LOOP] = loop_q;
`ifdef GPO_SEQ_IRQ_EN
            rd_data[CTRL_IRQ_EN] = irq_en_q;
`endif
          end
          ADDR_STATUS: begin
            rd_data[STAT_BUSY]            = (state_q == RUN);
            rd_data[STAT_DONE]            = done_q;
            rd_data[STAT_IDX_LSB +: 4]    = 4'(idx_q);
          end
          ADDR_LEN:     rd_data = 32'(len_q);
          ADDR_PRESC:   rd_data = 32'(presc_q);
          ADDR_IDLEVAL: rd_data = 32'(idleval_q);
          default:      rd_data = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpo_seq_core.sv
// tb/tb_gpo_seq_core.sv - directed scoreboard bench for gpo_seq_core
module tb_gpo_seq_core;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0, read = 1'b0, write = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic [7:0]  dout;
`ifdef GPO_SEQ_IRQ_EN
  logic        irq;
`endif

  int total = 0;
  int bad = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] r;

  always #5 clk = ~clk;

  gpo_seq_core #(.W(8), .DEPTH(16), .PRESC_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
`ifdef GPO_SEQ_IRQ_EN
    .irq     (irq),
`endif
    .dout    (dout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0; wr_data = '0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cs = 1'b1; read = 1'b1; addr = a;
    #1;
    d = rd_data;
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic drain(input string tag);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(tag, 32'(dout), 32'(e));
      @(negedge clk);
    end
  endtask

  task automatic push_n(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  initial begin
    @(negedge clk);
    chk("reset_dout", 32'(dout), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd(5'd1, r);  chk("reset_status", r, 32'h0);
    rd(5'd0, r);  chk("reset_ctrl", r, 32'h0);
    chk("rd_no_cs", rd_data, 32'h0);

    // one-shot
    wr(5'd3, 32'd0);
    wr(5'd2, 32'h13);
    rd(5'd2, r);  chk("len_wrap", r, 32'h3);
    wr(5'd2, 32'd2);
    wr(5'd16, {16'd2, 16'h00A5});
    wr(5'd17, {16'd1, 16'h003C});
    wr(5'd18, {16'd3, 16'h00FF});
    wr(5'd4, 32'h0);
    wr(5'd5, 32'hDEAD);
    rd(5'd5, r);  chk("unmapped_rd", r, 32'h0);
    rd(5'd17, r); chk("entry1_rd", r, 32'h0001003C);
    wr(5'd0, 32'h1);
    exp_q.push_back(8'hA5); exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    push_n(8'hFF, 3);       exp_q.push_back(8'h00);
    drain("oneshot_dout");
    rd(5'd1, r);  chk("oneshot_status", r & 32'h3, 32'h2);

    // loop with prescale
    wr(5'd4, 32'h55);
    chk("idleval_dout", 32'(dout), 32'h55);
    wr(5'd3, 32'd3);
    wr(5'd2, 32'd1);
    wr(5'd16, {16'd1, 16'h0001});
    wr(5'd17, {16'd0, 16'h0002});
    wr(5'd0, 32'h5);
    for (int p = 0; p < 3; p++) begin
      push_n(8'h01, 4);
      push_n(8'h02, 4);
    end
    drain("loop_dout");
    rd(5'd1, r);  chk("loop_status", r & 32'h3, 32'h1);

    // stop mid-entry
    wr(5'd0, 32'h6);
    chk("stop_dout", 32'(dout), 32'h55);
    rd(5'd1, r);  chk("stop_status", r & 32'h3, 32'h0);
    rd(5'd0, r);  chk("ctrl_loop_rd", r, 32'h4);

    // start+stop together stays idle
    wr(5'd0, 32'h3);
    @(negedge clk);
    chk("startstop_dout", 32'(dout), 32'h55);
    rd(5'd1, r);  chk("startstop_status", r & 32'h3, 32'h0);

    // restart during run
    wr(5'd0, 32'h5);
    push_n(8'h01, 4); exp_q.push_back(8'h02);
    drain("run_dout");
    wr(5'd0, 32'h5);
    rd(5'd1, r);  chk("restart_idx", r, 32'h1);
    push_n(8'h01, 4); exp_q.push_back(8'h02);
    drain("restart_dout");

    // edit the current entry: only its next visit changes
    wr(5'd17, {16'd0, 16'h0077});
    push_n(8'h02, 2); push_n(8'h01, 4); push_n(8'h77, 4);
    drain("edit_dout");

    // drop loop mid-run: finish at the end of this pass
    wr(5'd0, 32'h0);
    push_n(8'h01, 3); push_n(8'h77, 4); exp_q.push_back(8'h55);
    drain("finish_dout");
    rd(5'd1, r);  chk("finish_status", r & 32'h3, 32'h2);
    wr(5'd1, 32'h0);
    rd(5'd1, r);  chk("done_clear", r & 32'h3, 32'h0);

`ifdef GPO_SEQ_IRQ_EN
    wr(5'd3, 32'd0);
    wr(5'd2, 32'd0);
    wr(5'd0, 32'h8);
    rd(5'd0, r);  chk("irq_en_rd", r, 32'h8);
    chk("irq_idle", 32'(irq), 32'h0);
    wr(5'd0, 32'h9);
    chk("irq_run", 32'(irq), 32'h0);
    @(negedge clk);
    chk("irq_rise", 32'(irq), 32'h1);
    wr(5'd1, 32'h0);
    chk("irq_fall", 32'(irq), 32'h0);
`endif

    // asynchronous reset mid-run
    wr(5'd3, 32'd3);
    wr(5'd2, 32'd1);
    wr(5'd0, 32'h5);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_dout", 32'(dout), 32'h0);
    rd(5'd1, r);  chk("midrst_status", r, 32'h0);
    rd(5'd0, r);  chk("midrst_ctrl", r, 32'h0);
    rd(5'd4, r);  chk("midrst_idleval", r, 32'h0);
    for (int i = 16; i < 32; i++) begin
      rd(5'(i), r);
      chk("midrst_entry", r, 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("postrst_dout", 32'(dout), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpo_seq_core.md
Name: gpo_seq_core

Overview:
- MMIO slot core that sequences a W-bit general-purpose output through a programmable pattern table.
- Each entry has a pattern and a dwell time, measured in prescaled ticks.
- Sits in an FPro I/O slot beside the plain gpo core and drives LEDs or external pins with timed patterns.
- Software loads the table, sets the length and prescale, then starts one-shot or looped playback.

Parameters:
- W, 8, output width, 1..16.
- DEPTH, 16, pattern table entries, power of 2, 2..16.
- PRESC_W, 16, prescaler register width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cs  in  1  slot select.
- read  in  1  read strobe.
- write  in  1  write strobe.
- addr  in  5  word address within the slot.
- wr_data  in  32  write data.
- rd_data  out  32  read data.
- dout  out  W  sequenced output.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset_n is asynchronous, active-low.
- wr_en = cs && write.
- rd_data is combinational from addr when cs && read, else 0.
- Register map (word address):
  - 0 CTRL: write bit0 start (pulse), bit1 stop (pulse), bit2 loop (stored); reads {loop} at bit2, others 0.
  - 1 STATUS (RO): bit0 busy, bit1 done (sticky), bits[11:8] current index. Any write to addr 1 clears done.
  - 2 LEN [3:0]: last entry index, rw. Values ≥ DEPTH wrap modulo DEPTH.
  - 3 PRESC [PRESC_W-1:0]: rw. One tick every PRESC+1 clocks.
  - 4 IDLEVAL [W-1:0]: rw. dout value while IDLE.
  - 16+i ENTRY i (i < DEPTH): [W-1:0] pattern, [31:16] dwell, rw. Addresses ≥ 16+DEPTH are ignored and read 0.
  - Other addresses read 0; writes to them have no effect.
- Reset: all registers, table, and counters go to 0; state IDLE; dout = 0; busy = 0; done = 0.
- FSM IDLE:
  - dout = IDLEVAL, updated the cycle after an IDLEVAL write.
  - start -> RUN.
- Entering RUN (at the edge ending the start write cycle):
  - idx = 0, presc_cnt = 0, dwell_cnt = 0, dout <= ENTRY0.pattern, done cleared.
  - dout changes 1 cycle after the start write.
- FSM RUN, each clock:
  - presc_cnt increments; a tick occurs when presc_cnt == PRESC, then presc_cnt wraps to 0.
  - On a tick with dwell_cnt == max(dwell,1)-1, advance:
    - If idx < LEN: idx+1, dout <= next pattern, dwell_cnt = 0.
    - If idx == LEN and loop = 1: idx = 0, dout <= ENTRY0.pattern.
    - If idx == LEN and loop = 0: go to IDLE, done = 1, dout <= IDLEVAL.
  - On a tick otherwise, dwell_cnt+1.
  - Each entry is therefore held for max(dwell,1)*(PRESC+1) clocks.
- Stop in RUN: next cycle IDLE, dout = IDLEVAL, done unchanged (not set).
- Start in RUN: restarts from entry 0.
- Start and stop in the same write: stop wins.
- Table writes during RUN are allowed. The pattern is latched into dout at entry load, so editing the current entry affects its next visit only. Dwell and PRESC are read live.
- LEN written during RUN: the comparison uses the new value. If idx > new LEN, the sequence ends or loops at the next advance.
- reset_n asserted mid-run: immediate return to reset values.

Optional Feature:
- Macro GPO_SEQ_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit), registered, reset 0.
  - CTRL bit3 irq_en is stored and readable.
  - irq = done && irq_en, deasserting the cycle after done is cleared.
- Undefined: no irq port; CTRL bit3 is ignored and reads 0.

Decomposition:
- Package gpo_seq_pkg:
  - state enum {IDLE, RUN}.
  - register address localparams (CTRL, STATUS, LEN, PRESC, IDLEVAL, ENTRY_BASE = 16).
  - CTRL/STATUS bit position constants.
- Sub-module gpo_seq_tick: prescaler counter with clear input and tick output.

Test Plan:
- Reset: reset_n low mid-operation -> dout = 0, STATUS = 0, all entries read 0.
- One-shot:
  - Setup: PRESC = 0, LEN = 2; entries {0xA5, d2}, {0x3C, d1}, {0xFF, d3}; IDLEVAL = 0x00; start.
  - Expect dout A5,A5,3C,FF,FF,FF then 00.
  - STATUS.done = 1 and busy = 0 after 6 run cycles.
- Loop + prescale:
  - Setup: PRESC = 3, LEN = 1, loop = 1, entries {0x01, d1}, {0x02, d0}.
  - Expect dout alternating 01 ×4, 02 ×4 for at least 3 periods; done stays 0.
- Stop/restart:
  - Stop mid-entry -> dout = IDLEVAL next cycle, done = 0.
  - Start and stop in the same write -> remains IDLE.
  - Start during RUN -> entry 0 reappears next cycle.
- Live edits:
  - Rewrite the current entry pattern during RUN -> dout unchanged until its next visit.
  - Write to addr 1 -> done clears.
- IRQ (GPO_SEQ_IRQ_EN defined): irq_en = 1, one-shot completes -> irq rises with done, falls the cycle after the write to STATUS.
